// File: rtl/rv_pkg.sv
// rv_pkg: shared register-file types and configuration constants.
// Used by regfile_sb and regfile_scoreboard.
package rv_pkg;

  localparam int XLEN_DFLT = 32;
  localparam int NREGS_I = 32;
  localparam int NREGS_E = 16;

  typedef logic [$clog2(NREGS_I)-1:0] reg_addr_t;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits, set on issue, cleared on writeback.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback/issue onto the busy reads.
import rv_pkg::*;

module regfile_scoreboard #(
  parameter int NREGS = NREGS_I,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          set_en,
  input  logic [AW-1:0] set_a,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_a,
  input  logic [AW-1:0] a1,
  input  logic [AW-1:0] a2,
  output logic          busy1,
  output logic          busy2
);

  logic [NREGS-1:0] busy;

  // set follows clear so issue wins on a same-register collision
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_en && clr_a != '0) busy[clr_a] <= 1'b0;
      if (set_en && set_a != '0) busy[set_a] <= 1'b1;
    end
  end

  function automatic logic rd_busy(input logic [AW-1:0] a);
    logic b;
    b = (a == '0) ? 1'b0 : busy[a];
`ifdef REGFILE_BYPASS_EN
    if (clr_en && clr_a != '0 && clr_a == a)
      b = set_en && (set_a == a);
`endif
    return run && b;
  endfunction

  assign busy1 = rd_busy(a1);
  assign busy2 = rd_busy(a2);

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file, x0 = 0, reset clear-sweep and busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
import rv_pkg::*;

module regfile_sb #(
  parameter int XLEN = XLEN_DFLT,
  parameter int NREGS = NREGS_I,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we3,
  input  logic [AW-1:0]   a3,
  input  logic [XLEN-1:0] wd3,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  output logic            busy1,
  output logic            busy2,
  output logic            ready
);

  state_t          state;
  logic [AW-1:0]   idx;
  logic [XLEN-1:0] x [NREGS];
  logic            run;
  logic            wr;

  assign run = (state == RUN) && !rst;
  assign wr = run && we3 && (a3 != '0);
  assign ready = run;

  // x0 is never written; the read mux supplies its zero
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      idx <= AW'(1);
    end else begin
      unique case (state)
        CLEAR: begin
          x[idx] <= '0;
          idx <= idx + AW'(1);
          if (idx == AW'(NREGS - 1)) state <= RUN;
        end
        RUN: begin
          if (wr) x[a3] <= wd3;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  function automatic logic [XLEN-1:0] rd_mux(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = '0;
    if (run && a != '0) v = x[a];
`ifdef REGFILE_BYPASS_EN
    if (wr && a == a3) v = wd3;
`endif
    return v;
  endfunction

  assign rd1 = rd_mux(a1);
  assign rd2 = rd_mux(a2);

  regfile_scoreboard #(
    .NREGS(NREGS)
  ) u_sb (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .set_en(run && iss_en),
    .set_a (iss_rd),
    .clr_en(wr),
    .clr_a (a3),
    .a1    (a1),
    .a2    (a2),
    .busy1 (busy1),
    .busy2 (busy2)
  );

endmodule
